// File: rtl/dehaze_frame_ctrl.sv
// Frame controller for the dehaze transmission pipeline: streams one IMG_W x IMG_H frame
// into the pipe, optionally inserts line blanking, then drains and counts pipeline outputs.
module dehaze_frame_ctrl #(
  parameter int IMG_W    = 512,
  parameter int IMG_H    = 512,
  parameter int H_BLANK  = 0,
  parameter int DRAIN_TO = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] src_pixel,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [23:0] pipe_pixel,
  output logic        pipe_valid,
  input  logic        pipe_out_valid,
  output logic        sof,
  output logic        eol,
  output logic        busy,
  output logic        frame_done,
  output logic        err_timeout,
  output logic        err_overflow,
  output logic [19:0] in_count,
  output logic [19:0] out_count
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam int TW = $clog2(DRAIN_TO + 1);

  localparam logic [19:0]   TOTAL      = 20'(IMG_W * IMG_H);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [TW-1:0] TO_LAST    = TW'(DRAIN_TO - 1);

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    BLANK,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [BW-1:0] blank_cnt;
  logic [TW-1:0] drain_tmr;

  logic xfer;
  logic last_col;
  logic last_pix;
  logic out_full;
  logic out_inc;
  logic out_hit;
  logic drain_to_hit;

  assign src_ready  = (state == FEED);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  assign xfer     = src_valid && (state == FEED);
  assign last_col = (col == COL_LAST);
  assign last_pix = last_col && (row == ROW_LAST);
  assign out_full = (out_count == TOTAL);
  assign out_inc  = pipe_out_valid && !out_full && (state inside {FEED, BLANK, DRAIN});
  // DONE follows the cycle in which the final expected output is counted.
  assign out_hit      = out_full || (out_inc && (out_count == TOTAL - 20'd1));
  assign drain_to_hit = !pipe_out_valid && (drain_tmr == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: next state defaults to the current state before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = FEED;
      FEED: begin
        if (xfer && last_pix) begin
          state_nxt = DRAIN;
        end else if (xfer && last_col && (H_BLANK > 0)) begin
          state_nxt = BLANK;
        end
      end
      BLANK: if (blank_cnt == BLANK_LAST) state_nxt = FEED;
      DRAIN: if (out_hit || drain_to_hit) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_pixel   <= '0;
      pipe_valid   <= 1'b0;
      sof          <= 1'b0;
      eol          <= 1'b0;
      in_count     <= '0;
      out_count    <= '0;
      col          <= '0;
      row          <= '0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      pipe_valid <= xfer;
      sof        <= xfer && (in_count == 20'd0);
      eol        <= xfer && last_col;
      if (xfer) pipe_pixel <= src_pixel;

      if (state == IDLE && start) begin
        in_count     <= '0;
        out_count    <= '0;
        col          <= '0;
        row          <= '0;
        err_timeout  <= 1'b0;
        err_overflow <= 1'b0;
      end else begin
        if (xfer) begin
          in_count <= in_count + 20'd1;
          if (last_col) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        if (out_inc) out_count <= out_count + 20'd1;
        // Counts are frozen in IDLE, so a stray strobe there is not an overflow of this frame.
        if (pipe_out_valid && out_full && state != IDLE) err_overflow <= 1'b1;
        if (state == DRAIN && drain_to_hit && !out_hit) err_timeout <= 1'b1;
      end
    end
  end

  // Both timers sit at zero outside their state, which doubles as the clear-on-entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_cnt <= '0;
      drain_tmr <= '0;
    end else begin
      blank_cnt <= (state == BLANK) ? blank_cnt + BW'(1) : '0;
      drain_tmr <= (state == DRAIN && !pipe_out_valid) ? drain_tmr + TW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_dehaze_frame_ctrl.sv
// Scoreboard bench for dehaze_frame_ctrl: instance 0 runs without line blanking,
// instance 1 with three blank cycles per line; both use a 4x2 frame and a 16-cycle drain limit.
module tb_dehaze_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        start          [2];
  logic [23:0] src_pixel      [2];
  logic        src_valid      [2];
  logic        src_ready      [2];
  logic [23:0] pipe_pixel     [2];
  logic        pipe_valid     [2];
  logic        pipe_out_valid [2];
  logic        sof            [2];
  logic        eol            [2];
  logic        busy           [2];
  logic        frame_done     [2];
  logic        err_timeout    [2];
  logic        err_overflow   [2];
  logic [19:0] in_count       [2];
  logic [19:0] out_count      [2];

  int checks   = 0;
  int failures = 0;

  logic [25:0] sb_q [2][$];
  int          sb_idx [2];
  logic [25:0] sb_exp;

  int   r_pv, r_first, r_last, r_fd, r_gap, r_to_cyc, r_last_str, r_oc0, r_to0;
  logic r_busy_after;

  dehaze_frame_ctrl #(.IMG_W(W), .IMG_H(H), .H_BLANK(0), .DRAIN_TO(TO)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .src_pixel(src_pixel[0]),
    .src_valid(src_valid[0]), .src_ready(src_ready[0]), .pipe_pixel(pipe_pixel[0]),
    .pipe_valid(pipe_valid[0]), .pipe_out_valid(pipe_out_valid[0]), .sof(sof[0]),
    .eol(eol[0]), .busy(busy[0]), .frame_done(frame_done[0]), .err_timeout(err_timeout[0]),
    .err_overflow(err_overflow[0]), .in_count(in_count[0]), .out_count(out_count[0])
  );

  dehaze_frame_ctrl #(.IMG_W(W), .IMG_H(H), .H_BLANK(3), .DRAIN_TO(TO)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .src_pixel(src_pixel[1]),
    .src_valid(src_valid[1]), .src_ready(src_ready[1]), .pipe_pixel(pipe_pixel[1]),
    .pipe_valid(pipe_valid[1]), .pipe_out_valid(pipe_out_valid[1]), .sof(sof[1]),
    .eol(eol[1]), .busy(busy[1]), .frame_done(frame_done[1]), .err_timeout(err_timeout[1]),
    .err_overflow(err_overflow[1]), .in_count(in_count[1]), .out_count(out_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {sof, eol, pixel} is queued at each accepted transfer and retired at each pipe_valid.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        sb_q[k].delete();
        sb_idx[k] = 0;
      end else begin
        if (pipe_valid[k]) begin
          if (sb_q[k].size() == 0) begin
            check("sb_unexpected_pv", 32'(pipe_valid[k]), 32'd0);
          end else begin
            sb_exp = sb_q[k].pop_front();
            check("sb_out", 32'({sof[k], eol[k], pipe_pixel[k]}), 32'(sb_exp));
          end
        end
        if (src_valid[k] && src_ready[k]) begin
          sb_q[k].push_back({sb_idx[k] == 0, (sb_idx[k] % W) == W - 1, src_pixel[k]});
          sb_idx[k] = (sb_idx[k] + 1) % N;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int k, input string tag);
    check({tag, "_busy"},  32'(busy[k]),         32'd0);
    check({tag, "_ready"}, 32'(src_ready[k]),    32'd0);
    check({tag, "_pv"},    32'(pipe_valid[k]),   32'd0);
    check({tag, "_pix"},   32'(pipe_pixel[k]),   32'd0);
    check({tag, "_sof"},   32'(sof[k]),          32'd0);
    check({tag, "_eol"},   32'(eol[k]),          32'd0);
    check({tag, "_fd"},    32'(frame_done[k]),   32'd0);
    check({tag, "_to"},    32'(err_timeout[k]),  32'd0);
    check({tag, "_ovf"},   32'(err_overflow[k]), 32'd0);
    check({tag, "_inc"},   32'(in_count[k]),     32'd0);
    check({tag, "_outc"},  32'(out_count[k]),    32'd0);
  endtask

  // One frame with src_valid held high. Strobes return either once DRAIN is reached (late)
  // or one cycle behind each observed pipe_valid (early). Cycle indices count negedges after start.
  task automatic run_frame(input int k, input int n_str, input bit early, input bit strobe_on_start);
    int  sent;
    bit  fd_seen;
    sent = 0;
    fd_seen = 1'b0;
    r_pv = 0; r_first = -1; r_last = -1; r_fd = 0; r_gap = 0;
    r_to_cyc = -1; r_last_str = -1; r_oc0 = -1; r_to0 = -1; r_busy_after = 1'b1;
    tick();
    start[k] = 1'b1;
    src_valid[k] = 1'b1;
    src_pixel[k] = 24'($urandom);
    pipe_out_valid[k] = strobe_on_start;
    tick();
    start[k] = 1'b0;
    pipe_out_valid[k] = 1'b0;
    src_pixel[k] = 24'($urandom);
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        r_oc0 = int'(out_count[k]);
        r_to0 = int'(err_timeout[k]);
      end
      if (pipe_valid[k]) begin
        r_pv++;
        if (r_first < 0) r_first = cyc;
        r_last = cyc;
      end
      if (in_count[k] == 20'd4 && !src_ready[k] && busy[k]) r_gap++;
      if (err_timeout[k] && r_to_cyc < 0) r_to_cyc = cyc;
      if (frame_done[k]) r_fd++;
      if (fd_seen) begin
        r_busy_after = busy[k];
        break;
      end
      if (frame_done[k]) fd_seen = 1'b1;
      tick();
      src_pixel[k] = 24'($urandom);
      pipe_out_valid[k] = (sent < n_str) && (early ? (sent < r_pv) : (in_count[k] == 20'(N)));
      if (pipe_out_valid[k]) begin
        sent++;
        r_last_str = cyc + 1;
      end
    end
    src_valid[k] = 1'b0;
    pipe_out_valid[k] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      src_pixel[k] = '0;
      src_valid[k] = 1'b0;
      pipe_out_valid[k] = 1'b0;
    end
    #17;
    check_zero(0, "rst0");
    check_zero(1, "rst1");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Unblanked frame, all eight strobes returned in DRAIN.
    run_frame(0, N, 1'b0, 1'b0);
    check("f1_pv_count",   32'(r_pv), 32'(N));
    check("f1_first_pv",   32'(r_first), 32'd1);
    check("f1_pv_contig",  32'(r_last - r_first), 32'(N - 1));
    check("f1_no_gap",     32'(r_gap), 32'd0);
    check("f1_frame_done", 32'(r_fd), 32'd1);
    check("f1_busy_after", 32'(r_busy_after), 32'd0);
    check("f1_in_count",   32'(in_count[0]), 32'(N));
    check("f1_out_count",  32'(out_count[0]), 32'(N));
    check("f1_timeout",    32'(err_timeout[0]), 32'd0);
    check("f1_overflow",   32'(err_overflow[0]), 32'd0);

    // Seven strobes: drain timer expires after 16 idle cycles, visible the cycle after.
    run_frame(0, N - 1, 1'b0, 1'b0);
    check("f2_timeout",    32'(err_timeout[0]), 32'd1);
    check("f2_to_latency", 32'(r_to_cyc - r_last_str), 32'(TO + 1));
    check("f2_frame_done", 32'(r_fd), 32'd1);
    check("f2_busy_after", 32'(r_busy_after), 32'd0);
    check("f2_out_count",  32'(out_count[0]), 32'(N - 1));
    check("f2_overflow",   32'(err_overflow[0]), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_hold_outc", 32'(out_count[0]), 32'(N - 1));
    check("idle_hold_inc",  32'(in_count[0]), 32'(N));
    check("idle_hold_to",   32'(err_timeout[0]), 32'd1);

    // Start together with a strobe, then nine strobes: the extra one flags overflow.
    run_frame(0, N + 1, 1'b0, 1'b1);
    check("f3_start_clr_outc", 32'(r_oc0), 32'd0);
    check("f3_start_clr_to",   32'(r_to0), 32'd0);
    check("f3_overflow",       32'(err_overflow[0]), 32'd1);
    check("f3_out_count",      32'(out_count[0]), 32'(N));
    check("f3_frame_done",     32'(r_fd), 32'd1);
    check("f3_timeout",        32'(err_timeout[0]), 32'd0);

    // Blanked frame with strobes trailing pipe_valid through FEED, BLANK and DRAIN.
    run_frame(1, N, 1'b1, 1'b0);
    check("f4_blank_gap",  32'(r_gap), 32'd3);
    check("f4_pv_count",   32'(r_pv), 32'(N));
    check("f4_pv_span",    32'(r_last - r_first), 32'(N - 1 + 3));
    check("f4_frame_done", 32'(r_fd), 32'd1);
    check("f4_out_count",  32'(out_count[1]), 32'(N));
    check("f4_overflow",   32'(err_overflow[1]), 32'd0);
    check("f4_timeout",    32'(err_timeout[1]), 32'd0);

    // Mid-frame reset after five transfers, then a clean restart.
    tick();
    start[0] = 1'b1;
    src_valid[0] = 1'b1;
    src_pixel[0] = 24'($urandom);
    tick();
    start[0] = 1'b0;
    begin
      int n;
      n = 0;
      while (in_count[0] != 20'd5 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("f5_reach_five", 32'(in_count[0]), 32'd5);
    end
    #2 rst_n = 1'b0;
    #1 check_zero(0, "midrst");
    src_valid[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_frame(0, N, 1'b0, 1'b0);
    check("f6_first_pv",   32'(r_first), 32'd1);
    check("f6_pv_count",   32'(r_pv), 32'(N));
    check("f6_frame_done", 32'(r_fd), 32'd1);
    check("f6_out_count",  32'(out_count[0]), 32'(N));

    repeat (2) @(negedge clk);
    check("sb_left0", 32'(sb_q[0].size()), 32'd0);
    check("sb_left1", 32'(sb_q[1].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
